tictactoe_game_ctrl: RTL and testbench

//  Game sequencer for the 3x3 board. Owns the nine cell registers and alternates turns between

---
 rtl/tictactoe_game_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tictactoe_game_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tictactoe_game_ctrl.sv
// rtl/tictactoe_game_ctrl.sv - 3x3 game sequencer: board registers, turn FSM, move validation, result latch
//
// Purpose:
//   Owns the nine cell registers and alternates turns between X and O. A legal
//   request writes the cell, then one CHECK cycle samples the external winner
//   detector (which looks at o_pos1..o_pos9) to decide win, draw or next turn.
//
// Parameters:
//   FIRST_O       1 = O moves first after reset/new game, 0 = X first
//   MOVE_TIMEOUT  cycles allowed per turn before forfeit, 0 = disabled (max 65535)
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_new_game                synchronous restart (any state)
//   i_x_req/i_x_pos           X move request and target cell 1..9
//   i_o_req/i_o_pos           O move request and target cell 1..9
//   i_win_in/i_who_in         detector result (01 = X, 10 = O)
//   o_pos1..o_pos9            cell contents: 00 empty, 01 X, 10 O
//   o_turn                    01 X to move, 10 O to move, 00 otherwise
//   o_accept/o_illegal_move/o_timeout  single-cycle event pulses
//   o_move_count              cells filled, 0..9
//   o_game_over/o_winner/o_who/o_draw  final result

module tictactoe_game_ctrl #(
  parameter bit          FIRST_O      = 1'b0,
  parameter int unsigned MOVE_TIMEOUT = 0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_new_game,
  input  logic       i_x_req,
  input  logic [3:0] i_x_pos,
  input  logic       i_o_req,
  input  logic [3:0] i_o_pos,
  input  logic       i_win_in,
  input  logic [1:0] i_who_in,
  output logic [1:0] o_pos1,
  output logic [1:0] o_pos2,
  output logic [1:0] o_pos3,
  output logic [1:0] o_pos4,
  output logic [1:0] o_pos5,
  output logic [1:0] o_pos6,
  output logic [1:0] o_pos7,
  output logic [1:0] o_pos8,
  output logic [1:0] o_pos9,
  output logic [1:0] o_turn,
  output logic       o_accept,
  output logic       o_illegal_move,
  output logic       o_timeout,
  output logic [3:0] o_move_count,
  output logic       o_game_over,
  output logic       o_winner,
  output logic [1:0] o_who,
  output logic       o_draw
);

  typedef enum logic [1:0] {
    S_WAIT_X    = 2'd0,
    S_WAIT_O    = 2'd1,
    S_CHECK     = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  localparam state_t      START_STATE = FIRST_O ? S_WAIT_O : S_WAIT_X;
  localparam logic [1:0]  MARK_X      = 2'b01;
  localparam logic [1:0]  MARK_O      = 2'b10;
  localparam bit          TMO_EN      = (MOVE_TIMEOUT != 0);
  // Expiry fires on the MOVE_TIMEOUT-th cycle spent waiting (timer counts from 0).
  localparam logic [15:0] TMO_LAST    = TMO_EN ? 16'(MOVE_TIMEOUT - 1) : 16'd0;

  state_t      r_state;
  logic [1:0]  r_board [9];
  logic [3:0]  r_move_count;
  logic [1:0]  r_last;
  logic [15:0] r_timer;
  logic        r_accept;
  logic        r_illegal;
  logic        r_timeout;
  logic        r_winner;
  logic        r_draw;
  logic [1:0]  r_who;

  logic        w_waiting;
  logic        w_req;
  logic [3:0]  w_pos;
  logic [3:0]  w_idx;
  logic        w_pos_ok;
  logic [1:0]  w_cell;
  logic [1:0]  w_player;
  logic        w_legal;
  logic        w_expire;

  // Only the player whose turn it is gets looked at; the other request is dropped.
  always_comb begin
    w_waiting = (r_state == S_WAIT_X) || (r_state == S_WAIT_O);
    w_req     = 1'b0;
    w_pos     = 4'd0;
    w_player  = MARK_X;
    if (r_state == S_WAIT_X) begin
      w_req    = i_x_req;
      w_pos    = i_x_pos;
      w_player = MARK_X;
    end else if (r_state == S_WAIT_O) begin
      w_req    = i_o_req;
      w_pos    = i_o_pos;
      w_player = MARK_O;
    end
    w_pos_ok = (w_pos >= 4'd1) && (w_pos <= 4'd9);
    w_idx    = w_pos - 4'd1;
    w_cell   = w_pos_ok ? r_board[w_idx] : 2'b00;
    w_legal  = w_waiting && w_req && w_pos_ok && (w_cell == 2'b00);
    w_expire = TMO_EN && w_waiting && (r_timer == TMO_LAST);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_new_game) begin
      r_state      <= START_STATE;
      for (int i = 0; i < 9; i++) r_board[i] <= 2'b00;
      r_move_count <= 4'd0;
      r_last       <= 2'b00;
      r_timer      <= 16'd0;
      r_accept     <= 1'b0;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
      r_winner     <= 1'b0;
      r_draw       <= 1'b0;
      r_who        <= 2'b00;
    end else begin
      r_accept  <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_WAIT_X, S_WAIT_O: begin
          if (w_legal) begin
            // A legal move beats a same-cycle timer expiry.
            r_board[w_idx] <= w_player;
            r_move_count   <= r_move_count + 4'd1;
            r_last         <= w_player;
            r_accept       <= 1'b1;
            r_timer        <= 16'd0;
            r_state        <= S_CHECK;
          end else begin
            if (w_req) r_illegal <= 1'b1;
            if (w_expire) begin
              r_timeout <= 1'b1;
              r_timer   <= 16'd0;
              r_state   <= (r_state == S_WAIT_X) ? S_WAIT_O : S_WAIT_X;
            end else if (TMO_EN) begin
              r_timer <= r_timer + 16'd1;
            end
          end
        end
        S_CHECK: begin
          // Detector output already reflects the cell written last cycle.
          if (i_win_in) begin
            r_winner <= 1'b1;
            r_who    <= i_who_in;
            r_state  <= S_GAME_OVER;
          end else if (r_move_count == 4'd9) begin
            r_draw  <= 1'b1;
            r_who   <= 2'b00;
            r_state <= S_GAME_OVER;
          end else begin
            r_state <= (r_last == MARK_X) ? S_WAIT_O : S_WAIT_X;
          end
        end
        default: begin
          r_state <= S_GAME_OVER;
        end
      endcase
    end
  end

  assign o_pos1 = r_board[0];
  assign o_pos2 = r_board[1];
  assign o_pos3 = r_board[2];
  assign o_pos4 = r_board[3];
  assign o_pos5 = r_board[4];
  assign o_pos6 = r_board[5];
  assign o_pos7 = r_board[6];
  assign o_pos8 = r_board[7];
  assign o_pos9 = r_board[8];

  assign o_turn         = (r_state == S_WAIT_X) ? MARK_X :
                          (r_state == S_WAIT_O) ? MARK_O : 2'b00;
  assign o_game_over    = (r_state == S_GAME_OVER);
  assign o_accept       = r_accept;
  assign o_illegal_move = r_illegal;
  assign o_timeout      = r_timeout;
  assign o_move_count   = r_move_count;
  assign o_winner       = r_winner;
  assign o_who          = r_who;
  assign o_draw         = r_draw;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// tb/tb_tictactoe_game_ctrl.sv - table-driven scoreboard bench for tictactoe_game_ctrl
module tb_tictactoe_game_ctrl;

  localparam logic [1:0] X = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] N = 2'b00;

  logic       clk = 1'b0;
  logic       reset, new_game, x_req, o_req, win_in;
  logic [3:0] x_pos, o_pos;
  logic [1:0] who_in;
  logic [1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic [1:0] turn, who;
  logic       accept, illegal_move, timeout, game_over, winner, draw;
  logic [3:0] move_count;
  logic [1:0] pv [1:9];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tictactoe_game_ctrl #(.FIRST_O(1'b0), .MOVE_TIMEOUT(8)) dut (
    .i_clock(clk), .i_reset(reset), .i_new_game(new_game),
    .i_x_req(x_req), .i_x_pos(x_pos), .i_o_req(o_req), .i_o_pos(o_pos),
    .i_win_in(win_in), .i_who_in(who_in),
    .o_pos1(p1), .o_pos2(p2), .o_pos3(p3), .o_pos4(p4), .o_pos5(p5),
    .o_pos6(p6), .o_pos7(p7), .o_pos8(p8), .o_pos9(p9),
    .o_turn(turn), .o_accept(accept), .o_illegal_move(illegal_move),
    .o_timeout(timeout), .o_move_count(move_count), .o_game_over(game_over),
    .o_winner(winner), .o_who(who), .o_draw(draw)
  );

  // Reference winner detector: combinational over the board the DUT exposes.
  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
  always_comb begin
    pv[1] = p1; pv[2] = p2; pv[3] = p3; pv[4] = p4; pv[5] = p5;
    pv[6] = p6; pv[7] = p7; pv[8] = p8; pv[9] = p9;
    win_in = 1'b0;
    who_in = 2'b00;
    for (int l = 0; l < 8; l++) begin
      if (pv[lines[l][0]] != 2'b00 && pv[lines[l][0]] == pv[lines[l][1]] &&
          pv[lines[l][1]] == pv[lines[l][2]]) begin
        win_in = 1'b1;
        who_in = pv[lines[l][0]];
      end
    end
  end

  // exp = {accept, illegal, timeout, turn[1:0], count[3:0], game_over, winner, who[1:0], draw}
  typedef struct packed {
    logic        ng;
    logic        xr;
    logic [3:0]  xp;
    logic        orq;
    logic [3:0]  op;
    logic [13:0] exp;
    logic [3:0]  cc;
    logic [1:0]  cv;
  } vec_t;

  vec_t        tbl [$];
  logic [13:0] exp_q [$];

  function automatic logic [13:0] e(logic acc, logic ill, logic to, logic [1:0] t,
                                    logic [3:0] cnt, logic go, logic w,
                                    logic [1:0] wh, logic dr);
    return {acc, ill, to, t, cnt, go, w, wh, dr};
  endfunction

  function automatic void add(logic ng, logic xr, logic [3:0] xp, logic orq,
                              logic [3:0] op, logic [13:0] ex,
                              logic [3:0] cc, logic [1:0] cv);
    vec_t v;
    v.ng = ng; v.xr = xr; v.xp = xp; v.orq = orq; v.op = op;
    v.exp = ex; v.cc = cc; v.cv = cv;
    tbl.push_back(v);
  endfunction

  // Legal move followed by the CHECK idle cycle; next_turn is what follows CHECK.
  function automatic void mv(logic [1:0] pl, logic [3:0] pos, logic [3:0] cnt,
                             logic [1:0] next_turn);
    add(0, pl == X, (pl == X) ? pos : 4'd0, pl == O, (pl == O) ? pos : 4'd0,
        e(1,0,0,N,cnt,0,0,N,0), pos, pl);
    add(0, 0, 0, 0, 0, e(0,0,0,next_turn,cnt,0,0,N,0), 0, N);
  endfunction

  logic [13:0] got, want;

  initial begin
    reset = 1'b1; new_game = 1'b0; x_req = 1'b0; o_req = 1'b0;
    x_pos = 4'd0; o_pos = 4'd0;

    // Test 2: X wins on the top row, later requests ignored.
    add(0,1,4'd1,0,0, e(1,0,0,N,1,0,0,N,0), 1, X);
    add(0,0,0,0,0,    e(0,0,0,O,1,0,0,N,0), 0, N);
    mv(O, 4, 2, X);
    mv(X, 2, 3, O);
    mv(O, 5, 4, X);
    add(0,1,4'd3,0,0, e(1,0,0,N,5,0,0,N,0), 3, X);
    add(0,0,0,0,0,    e(0,0,0,N,5,1,1,X,0), 0, N);
    add(0,1,4'd7,0,0, e(0,0,0,N,5,1,1,X,0), 7, N);
    add(0,0,0,1,4'd7, e(0,0,0,N,5,1,1,X,0), 7, N);
    add(0,1,4'd0,1,4'd0, e(0,0,0,N,5,1,1,X,0), 0, N);

    // Test 3: occupied / out-of-range targets, wrong-player requests.
    add(1,0,0,0,0,    e(0,0,0,X,0,0,0,N,0), 1, N);
    add(0,1,4'd5,0,0, e(1,0,0,N,1,0,0,N,0), 5, X);
    add(0,0,0,0,0,    e(0,0,0,O,1,0,0,N,0), 0, N);
    add(0,0,0,1,4'd5, e(0,1,0,O,1,0,0,N,0), 5, X);
    add(0,0,0,1,4'd0, e(0,1,0,O,1,0,0,N,0), 0, N);
    add(0,0,0,1,4'd12,e(0,1,0,O,1,0,0,N,0), 0, N);
    add(0,1,4'd1,0,0, e(0,0,0,O,1,0,0,N,0), 1, N);
    add(0,1,4'd2,1,4'd5, e(0,1,0,O,1,0,0,N,0), 2, N);
    mv(O, 1, 2, X);

    // Test 4: full board, no line -> draw.
    add(1,0,0,0,0,    e(0,0,0,X,0,0,0,N,0), 5, N);
    mv(X, 1, 1, O); mv(O, 2, 2, X); mv(X, 3, 3, O); mv(O, 5, 4, X);
    mv(X, 4, 5, O); mv(O, 6, 6, X); mv(X, 8, 7, O); mv(O, 7, 8, X);
    add(0,1,4'd9,0,0, e(1,0,0,N,9,0,0,N,0), 9, X);
    add(0,0,0,0,0,    e(0,0,0,N,9,1,0,N,1), 0, N);
    add(0,0,0,1,4'd1, e(0,0,0,N,9,1,0,N,1), 0, N);

    // Test 5: new_game during CHECK after three moves.
    add(1,0,0,0,0,    e(0,0,0,X,0,0,0,N,0), 9, N);
    mv(X, 1, 1, O); mv(O, 2, 2, X);
    add(0,1,4'd3,0,0, e(1,0,0,N,3,0,0,N,0), 3, X);
    add(1,0,0,0,0,    e(0,0,0,X,0,0,0,N,0), 3, N);
    add(0,0,0,0,0,    e(0,0,0,X,0,0,0,N,0), 1, N);

    // Test 6: 8-cycle turn timer; expiry forfeits, a move on the 8th cycle wins.
    add(1,0,0,0,0,    e(0,0,0,X,0,0,0,N,0), 2, N);
    for (int k = 0; k < 7; k++) add(0,0,0,0,0, e(0,0,0,X,0,0,0,N,0), 0, N);
    add(0,0,0,0,0,    e(0,0,1,O,0,0,0,N,0), 5, N);
    for (int k = 0; k < 7; k++) add(0,0,0,0,0, e(0,0,0,O,0,0,0,N,0), 0, N);
    add(0,0,0,1,4'd5, e(1,0,0,N,1,0,0,N,0), 5, O);
    add(0,0,0,0,0,    e(0,0,0,X,1,0,0,N,0), 0, N);
    for (int k = 0; k < 7; k++) add(0,0,0,0,0, e(0,0,0,X,1,0,0,N,0), 0, N);
    add(0,1,4'd1,0,0, e(1,0,0,N,2,0,0,N,0), 1, X);
    add(0,0,0,0,0,    e(0,0,0,O,2,0,0,N,0), 0, N);

    // Test 1: reset held two cycles.
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    want = e(0,0,0,X,0,0,0,N,0);
    got  = {accept, illegal_move, timeout, turn, move_count, game_over, winner, who, draw};
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL reset_outputs: got %b want %b", got, want);
    n_total++;
    if ({p1,p2,p3,p4,p5,p6,p7,p8,p9} === 18'd0) n_pass++;
    else $display("FAIL reset_board: got %b want 0", {p1,p2,p3,p4,p5,p6,p7,p8,p9});

    for (int i = 0; i < tbl.size(); i++) begin
      new_game = tbl[i].ng;
      x_req = tbl[i].xr; x_pos = tbl[i].xp;
      o_req = tbl[i].orq; o_pos = tbl[i].op;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk); #1;
      got  = {accept, illegal_move, timeout, turn, move_count, game_over, winner, who, draw};
      want = exp_q.pop_front();
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL step%0d: got acc/ill/to/turn/cnt/go/win/who/draw=%b want %b", i, got, want);
      if (tbl[i].cc != 4'd0) begin
        n_total++;
        if (pv[tbl[i].cc] === tbl[i].cv) n_pass++;
        else $display("FAIL step%0d_pos%0d: got %b want %b", i, tbl[i].cc, pv[tbl[i].cc], tbl[i].cv);
      end
    end

    new_game = 1'b0; x_req = 1'b0; o_req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
